// File: rtl/gpio_switch_debounce_pkg.sv
// Shared switch-interface constants and the constant-width helper used by
// the debounce logic.
package gpio_defs;

    localparam int unsigned NUM_SWITCHES    = 4;
    localparam int unsigned SYS_CLK_HZ      = 100_000_000;
    localparam int unsigned DEBOUNCE_MS     = 10;
    localparam int unsigned DEBOUNCE_CYCLES = (SYS_CLK_HZ / 1000) * DEBOUNCE_MS;

    // Bits needed to hold values 0..v-1 (at least 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/gpio_switch_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter, debounced level
// and one-cycle rise/fall pulses.
module debounce_bit
    import gpio_defs::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = gpio_defs::DEBOUNCE_CYCLES,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_state,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned          CW   = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]        LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_count;
    logic                   r_state;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign o_state = r_state;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_count <= '0;
            r_state <= RESET_VALUE;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // Any agreement with the current level restarts the stability count.
            if (w_sync == r_state) begin
                r_count <= '0;
            end else if (r_count == LAST) begin
                r_count <= '0;
                r_state <= w_sync;
                r_rise  <= w_sync;
                r_fall  <= ~w_sync;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_switch_debounce.sv
// Slide-switch conditioner: per-bit debounce, post-reset settle window and
// masking of edge pulses until the settle window has elapsed.
module gpio_switch_debounce
    import gpio_defs::*;
#(
    parameter int unsigned     WIDTH           = NUM_SWITCHES,
    parameter int unsigned     SYNC_STAGES     = 2,
    parameter int unsigned     DEBOUNCE_CYCLES = gpio_defs::DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic             SYSTEMCLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] gpio_switch,
    output logic [WIDTH-1:0] switch_state,
    output logic [WIDTH-1:0] switch_rise,
    output logic [WIDTH-1:0] switch_fall,
    output logic             switch_changed,
    output logic             switch_valid
);

    localparam int unsigned   SETTLE = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int unsigned   SW     = clog2(SETTLE + 1);
    localparam logic [SW-1:0] SLAST  = SW'(SETTLE - 1);

    logic [SW-1:0]    r_settle;
    logic             r_valid;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    always_ff @(posedge SYSTEMCLOCK) begin
        if (RESET) begin
            r_settle <= '0;
            r_valid  <= 1'b0;
        end else if (!r_valid) begin
            if (r_settle == SLAST) r_valid <= 1'b1;
            else                   r_settle <= r_settle + 1'b1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VALUE    (RESET_VALUE[g])
        ) u_bit (
            .i_clk  (SYSTEMCLOCK),
            .i_rst  (RESET),
            .i_pin  (gpio_switch[g]),
            .o_state(switch_state[g]),
            .o_rise (w_rise[g]),
            .o_fall (w_fall[g])
        );
    end

    // Edges accepted before the settle window ends are power-up artefacts.
    assign switch_rise    = w_rise & {WIDTH{r_valid}};
    assign switch_fall    = w_fall & {WIDTH{r_valid}};
    assign switch_changed = |(switch_rise | switch_fall);
    assign switch_valid   = r_valid;

endmodule

// File: tb/tb_gpio_switch_debounce.sv
// Bench for gpio_switch_debounce: directed vector table plus randomized pins
// checked every cycle against a sliding-window reference model.
module tb_gpio_switch_debounce;

    localparam int W      = 4;
    localparam int SYNC   = 2;
    localparam int DEB    = 16;
    localparam int SETTLE = SYNC + DEB + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pin = '0;
    logic [W-1:0] st, rise, fall;
    logic         chg, val;

    int total = 0;
    int bad   = 0;

    gpio_switch_debounce #(
        .WIDTH          (W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_VALUE    (4'h0)
    ) dut (
        .SYSTEMCLOCK   (clk),
        .RESET         (rst),
        .gpio_switch   (pin),
        .switch_state  (st),
        .switch_rise   (rise),
        .switch_fall   (fall),
        .switch_changed(chg),
        .switch_valid  (val)
    );

    always #5 clk = ~clk;

    // Reference: a level is accepted once the last DEB synchronised samples
    // all disagree with the current level; sync sample = pin from SYNC edges ago.
    logic [W-1:0] pq[$];
    logic [W-1:0] sq[$];
    logic [W-1:0] m_state = '0, m_rise = '0, m_fall = '0, m_prev, m_s;
    logic         m_valid = 1'b0;
    int           m_since = 0;
    bit           alldiff;

    always @(posedge clk) begin
        if (rst) begin
            pq.delete();
            sq.delete();
            repeat (SYNC) pq.push_back('0);
            repeat (DEB) sq.push_back('0);
            m_state = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_valid = 1'b0;
            m_since = 0;
        end else begin
            m_s = pq.pop_front();
            pq.push_back(pin);
            void'(sq.pop_front());
            sq.push_back(m_s);
            m_prev = m_state;
            for (int b = 0; b < W; b++) begin
                alldiff = 1'b1;
                foreach (sq[j]) if (sq[j][b] == m_prev[b]) alldiff = 1'b0;
                if (alldiff) m_state[b] = ~m_prev[b];
            end
            if (m_since < SETTLE) m_since++;
            m_valid = (m_since >= SETTLE);
            m_rise  = m_valid ? (m_state & ~m_prev) : '0;
            m_fall  = m_valid ? (~m_state & m_prev) : '0;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("model_state", st, m_state);
            chk("model_rise", rise, m_rise);
            chk("model_fall", fall, m_fall);
            chk("model_changed", {3'b0, chg}, {3'b0, |(m_rise | m_fall)});
            chk("model_valid", {3'b0, val}, {3'b0, m_valid});
        end
    endtask

    typedef struct {
        logic         rst;
        logic [W-1:0] pin;
        int           cyc;
        logic [W-1:0] st;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
        logic         val;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [W-1:0] p, input int c,
                                input logic [W-1:0] s, input logic [W-1:0] ri,
                                input logic [W-1:0] fa, input logic ch, input logic v);
        vec_t t;
        t.rst = r; t.pin = p; t.cyc = c; t.st = s;
        t.rise = ri; t.fall = fa; t.chg = ch; t.val = v;
        return t;
    endfunction

    initial begin
        // reset and settle window
        tbl.push_back(mk(1, 4'h0,  2, 4'h0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 18, 4'h0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h0,  1, 4'h0, 4'h0, 4'h0, 0, 1));
        // clean rise on bit0: 18-cycle latency, single pulse
        tbl.push_back(mk(0, 4'h1, 17, 4'h0, 4'h0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h1,  1, 4'h1, 4'h1, 4'h0, 1, 1));
        tbl.push_back(mk(0, 4'h1,  1, 4'h1, 4'h0, 4'h0, 0, 1));
        // 10-cycle glitch on bit1
        tbl.push_back(mk(0, 4'h3, 10, 4'h1, 4'h0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h1, 30, 4'h1, 4'h0, 4'h0, 0, 1));
        // bounce on bit2 every 5 cycles, then hold high
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(0, (k % 2 == 0) ? 4'h5 : 4'h1, 5, 4'h1, 4'h0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h5, 17, 4'h1, 4'h0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h5,  1, 4'h5, 4'h4, 4'h0, 1, 1));
        tbl.push_back(mk(0, 4'h5,  1, 4'h5, 4'h0, 4'h0, 0, 1));
        // move to 9, then all bits fall together
        tbl.push_back(mk(0, 4'h9, 18, 4'h9, 4'h8, 4'h4, 1, 1));
        tbl.push_back(mk(0, 4'h9,  1, 4'h9, 4'h0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 17, 4'h9, 4'h0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h0,  1, 4'h0, 4'h0, 4'h9, 1, 1));
        tbl.push_back(mk(0, 4'h0,  1, 4'h0, 4'h0, 4'h0, 0, 1));
        // reset while bit3 is mid-count; accepted after release without a pulse
        tbl.push_back(mk(0, 4'h8, 10, 4'h0, 4'h0, 4'h0, 0, 1));
        tbl.push_back(mk(1, 4'h8,  1, 4'h0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h8, 17, 4'h0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h8,  1, 4'h8, 4'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h8,  1, 4'h8, 4'h0, 4'h0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            pin = tbl[i].pin;
            tick(tbl[i].cyc);
            chk($sformatf("vec%0d_state", i), st, tbl[i].st);
            chk($sformatf("vec%0d_rise", i), rise, tbl[i].rise);
            chk($sformatf("vec%0d_fall", i), fall, tbl[i].fall);
            chk($sformatf("vec%0d_changed", i), {3'b0, chg}, {3'b0, tbl[i].chg});
            chk($sformatf("vec%0d_valid", i), {3'b0, val}, {3'b0, tbl[i].val});
        end

        // randomized pin activity with occasional resets
        for (int seg = 0; seg < 80; seg++) begin
            if ($urandom_range(0, 11) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 2));
                rst = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                pin = pin ^ (4'h1 << $urandom_range(0, W - 1));
                tick($urandom_range(1, 12));
            end else begin
                pin = W'($urandom);
                tick($urandom_range(1, 40));
            end
        end
        tick(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
